// File: rtl/mau_seq_ctrl_4b.sv
// Command sequencer for the 4-bit MAU datapath: splits one W-bit operation into
// LSB-first nibble passes with carry chaining and returns the reassembled result.
module mau_seq_ctrl_4b #(
  parameter int unsigned NIBBLES = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [4*NIBBLES-1:0]   cmd_a,
  input  logic [4*NIBBLES-1:0]   cmd_b,
  output logic                   alu_start,
  output logic [2:0]             alu_op,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  input  logic                   alu_done,
  input  logic [3:0]             alu_y,
  input  logic                   alu_cout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_y,
  output logic                   rsp_cout,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned TW    = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } op_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [NIB_W-1:0] nib_q, nib_d;
  logic             carry_q, carry_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [W-1:0]     result_q, result_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_err_q, rsp_err_d;

  logic is_sub;
  logic is_arith;

  assign is_sub   = (op_q == OP_SUB);
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    nib_d      = nib_q;
    carry_d    = carry_q;
    timer_d    = timer_q;
    result_d   = result_q;
    rsp_cout_d = rsp_cout_q;
    rsp_err_d  = rsp_err_q;

    // ena low freezes every register, so all transitions live under it
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_d       = cmd_op;
            a_d        = cmd_a;
            b_d        = cmd_b;
            nib_d      = '0;
            carry_d    = 1'b0;
            timer_d    = '0;
            result_d   = '0;
            rsp_cout_d = 1'b0;
            if (cmd_op <= OP_XOR) begin
              rsp_err_d = 1'b0;
              state_d   = S_ISSUE;
            end else begin
              rsp_err_d = 1'b1;
              state_d   = S_RESP;
            end
          end
        end
        S_ISSUE: begin
          timer_d = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (alu_done) begin
            result_d[4*nib_q +: 4] = alu_y;
            carry_d                = alu_cout;
            if (nib_q == NIB_W'(NIBBLES - 1)) begin
              rsp_cout_d = is_arith ? alu_cout : 1'b0;
              state_d    = S_RESP;
            end else begin
              nib_d   = nib_q + NIB_W'(1);
              state_d = S_ISSUE;
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            rsp_err_d  = 1'b1;
            rsp_cout_d = 1'b0;
            state_d    = S_RESP;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      nib_q      <= '0;
      carry_q    <= 1'b0;
      timer_q    <= '0;
      result_q   <= '0;
      rsp_cout_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      nib_q      <= nib_d;
      carry_q    <= carry_d;
      timer_q    <= timer_d;
      result_q   <= result_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // ALU-side operands decode straight from registers that only change on pass exit
  assign alu_start = ena && (state_q == S_ISSUE);
  assign alu_op    = is_sub ? OP_ADD : op_q;
  assign alu_a     = a_q[4*nib_q +: 4];
  assign alu_b     = is_sub ? ~b_q[4*nib_q +: 4] : b_q[4*nib_q +: 4];
  assign alu_cin   = !is_arith ? 1'b0 : ((nib_q == '0) ? is_sub : carry_q);

  assign cmd_ready = rst_n && ena && (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_y     = result_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mau_seq_ctrl_4b.sv
// Bench for mau_seq_ctrl_4b: ALU stub with programmable done delay, whole-word
// arithmetic reference model, directed scenarios followed by random commands.
module tb_mau_seq_ctrl_4b;

  localparam int unsigned NIB = 2;
  localparam int unsigned TO  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       alu_start;
  logic [2:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_cin;
  logic       alu_done;
  logic [3:0] alu_y;
  logic       alu_cout;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_y;
  logic       rsp_cout;
  logic       rsp_err;
  logic       busy;

  mau_seq_ctrl_4b #(.NIBBLES(NIB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_done(alu_done), .alu_y(alu_y), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Stub controls written only by the main sequence
  int stub_dly  = 1;
  int stub_mode = 0;  // 0 normal, 1 never done, 2 done on first pass only
  int base_cnt  = 0;

  // Stub state written only by the stub process
  int         start_cnt = 0;
  logic [3:0] cap_a  [16];
  logic [3:0] cap_b  [16];
  logic       cap_cin[16];
  logic [2:0] cap_op [16];

  initial begin
    bit         pend;
    int         cnt;
    logic [4:0] res;
    pend     = 0;
    cnt      = 0;
    alu_done = 1'b0;
    alu_y    = 4'h0;
    alu_cout = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      alu_done = 1'b0;
      if (!rst_n) pend = 0;
      else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          alu_done = 1'b1;
          alu_y    = res[3:0];
          alu_cout = res[4];
          pend     = 0;
        end
      end
      @(negedge clk);
      if (rst_n && alu_start) begin
        cap_a[start_cnt % 16]   = alu_a;
        cap_b[start_cnt % 16]   = alu_b;
        cap_cin[start_cnt % 16] = alu_cin;
        cap_op[start_cnt % 16]  = alu_op;
        case (alu_op)
          3'd0:    res = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_cin};
          3'd2:    res = {1'b0, alu_a & alu_b};
          3'd3:    res = {1'b0, alu_a | alu_b};
          3'd4:    res = {1'b0, alu_a ^ alu_b};
          default: res = 5'h0;
        endcase
        pend = (stub_mode == 0) || (stub_mode == 2 && (start_cnt - base_cnt) == 0);
        cnt  = stub_dly;
        start_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: {err, cout, y}
  function automatic logic [9:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int s;
    case (op)
      3'd0: begin s = int'(a) + int'(b); return {1'b0, s[8], s[7:0]}; end
      3'd1: begin s = int'(a) - int'(b); return {1'b0, (a >= b), s[7:0]}; end
      3'd2: return {2'b00, a & b};
      3'd3: return {2'b00, a | b};
      3'd4: return {2'b00, a ^ b};
      default: return {1'b1, 9'h0};
    endcase
  endfunction

  // Carry entering nibble n is bit 4n of the low-part sum of A and the issued B
  function automatic logic exp_cin(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int n);
    int bx, c0, mask, s;
    if (op > 3'd1) return 1'b0;
    c0 = (op == 3'd1) ? 1 : 0;
    if (n == 0) return c0[0];
    bx   = (op == 3'd1) ? int'(~b) : int'(b);
    mask = (1 << (4 * n)) - 1;
    s    = (int'(a) & mask) + (bx & mask) + c0;
    return s[4*n];
  endfunction

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bit acc = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      if (acc) base_cnt = start_cnt;
      @(posedge clk);
      if (acc) break;
    end
    chk("cmd_accept", 32'(acc), 32'd1);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, output logic [7:0] y, output logic c, output logic e, output int lat);
    bit got = 0;
    lat = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; break; end
      @(posedge clk);
      #1;
      lat++;
    end
    chk("rsp_arrives", 32'(got), 32'd1);
    y = rsp_y;
    c = rsp_cout;
    e = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_stable", 32'({rsp_valid, rsp_y, rsp_cout, rsp_err, cmd_ready, busy}),
          32'({1'b1, y, c, e, 1'b0, 1'b1}));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] y, input logic c, input logic e);
    logic [9:0] m;
    m = model(op, a, b);
    chk({tag, "_y"}, 32'(y), 32'(m[7:0]));
    chk({tag, "_cout"}, 32'(c), 32'(m[8]));
    chk({tag, "_err"}, 32'(e), 32'(m[9]));
  endtask

  task automatic check_passes(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] bx;
    int         idx;
    bx = (op == 3'd1) ? ~b : b;
    chk({tag, "_starts"}, 32'(start_cnt - base_cnt), 32'(NIB));
    for (int n = 0; n < int'(NIB); n++) begin
      idx = (base_cnt + n) % 16;
      chk({tag, "_alu_a"}, 32'(cap_a[idx]), 32'(a[4*n +: 4]));
      chk({tag, "_alu_b"}, 32'(cap_b[idx]), 32'(bx[4*n +: 4]));
      chk({tag, "_alu_cin"}, 32'(cap_cin[idx]), 32'(exp_cin(op, a, b, n)));
      chk({tag, "_alu_op"}, 32'(cap_op[idx]), 32'((op == 3'd1) ? 3'd0 : op));
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input int exp_lat);
    logic [7:0] y;
    logic       c, e;
    int         lat;
    send_cmd(op, a, b);
    get_rsp(0, y, c, e, lat);
    check_result(tag, op, a, b, y, c, e);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (op <= 3'd4) check_passes(tag, op, a, b);
    else chk({tag, "_no_start"}, 32'(start_cnt - base_cnt), 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({cmd_ready, alu_start, alu_op, alu_a, alu_b, alu_cin,
                rsp_valid, rsp_y, rsp_cout, rsp_err, busy});
  endfunction

  initial begin
    logic [7:0] y;
    logic       c, e;
    int         lat;
    logic [2:0] rop;
    logic [7:0] ra, rb;

    rst_n     = 1'b0;
    ena       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_a     = 8'h0;
    cmd_b     = 8'h0;
    rsp_ready = 1'b0;
    #12;
    chk("reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", 32'({cmd_ready, busy, rsp_valid}), 32'b100);

    // Directed: carry chain, subtraction, wrap, logic op, slow ALU
    stub_dly = 1;
    run("add_3a_29", 3'd0, 8'h3A, 8'h29, 5);
    run("sub_10_01", 3'd1, 8'h10, 8'h01, 5);
    run("add_ff_01", 3'd0, 8'hFF, 8'h01, 5);
    run("xor_a5_ff", 3'd4, 8'hA5, 8'hFF, 5);
    stub_dly = 3;
    run("xor_slow", 3'd4, 8'hA5, 8'hFF, 9);
    stub_dly = 1;
    run("illegal_110", 3'b110, 8'h12, 8'h34, 1);

    // Timeout with no done, then with only the first pass completing
    stub_mode = 1;
    send_cmd(3'd0, 8'h12, 8'h34);
    get_rsp(0, y, c, e, lat);
    chk("to_none_latency", 32'(lat), 32'(TO + 2));
    chk("to_none_rsp", 32'({y, c, e}), 32'({8'h00, 1'b0, 1'b1}));
    chk("to_none_starts", 32'(start_cnt - base_cnt), 32'd1);
    stub_mode = 2;
    send_cmd(3'd0, 8'h34, 8'h03);
    get_rsp(0, y, c, e, lat);
    chk("to_nib0_latency", 32'(lat), 32'(TO + 4));
    chk("to_nib0_rsp", 32'({y, c, e}), 32'({8'h07, 1'b0, 1'b1}));
    stub_mode = 0;

    // Response back-pressure
    send_cmd(3'd0, 8'h12, 8'h34);
    get_rsp(10, y, c, e, lat);
    check_result("bp", 3'd0, 8'h12, 8'h34, y, c, e);

    // ena low mid-WAIT: timer must freeze or the long first pass times out
    stub_dly = 10;
    send_cmd(3'd0, 8'h5C, 8'h17);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alu_start) break;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    ena = 1'b0;
    stub_dly = 1;
    @(negedge clk);
    chk("ena_low_outs", 32'({cmd_ready, alu_start, busy}), 32'b001);
    repeat (4) @(posedge clk);
    #1;
    ena = 1'b1;
    get_rsp(0, y, c, e, lat);
    check_result("ena_wait", 3'd0, 8'h5C, 8'h17, y, c, e);

    // ena low while ISSUE is pending: start must wait, then fire once
    send_cmd(3'd1, 8'h80, 8'h81);
    ena = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ena_issue_hold", 32'(alu_start), 32'd0);
    end
    ena = 1'b1;
    get_rsp(0, y, c, e, lat);
    check_result("ena_issue", 3'd1, 8'h80, 8'h81, y, c, e);
    check_passes("ena_issue", 3'd1, 8'h80, 8'h81);

    // Reset in WAIT aborts, then a clean command follows
    stub_dly = 10;
    send_cmd(3'd0, 8'h44, 8'h22);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_in_wait", all_outs(), 32'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    stub_dly = 1;
    run("after_reset", 3'd0, 8'h01, 8'h01, 5);

    // Random commands against the reference model
    for (int i = 0; i < 16; i++) begin
      rop      = 3'($urandom_range(0, 5));
      ra       = 8'($urandom);
      rb       = 8'($urandom);
      stub_dly = int'($urandom_range(1, 3));
      run("rand", rop, ra, rb, (rop <= 3'd4) ? (int'(NIB) * (1 + stub_dly) + 1) : 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
